// File: rtl/flyback_axil_pkg.sv
// Shared constants and helpers for the flyback controller AXI4-Lite register file.
`timescale 1ns/1ps
package flyback_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] CTRL0       = 3'd0;
    localparam logic [2:0] CTRL1       = 3'd1;
    localparam logic [2:0] CTRL2       = 3'd2;
    localparam logic [2:0] CTRL3       = 3'd3;
    localparam logic [2:0] STATUS      = 3'd4;
    localparam logic [2:0] VERSION_IDX = 3'd5;
    localparam logic [2:0] NUM_WORDS   = 3'd6;

    localparam logic [31:0] DEFAULT_VERSION = 32'h0001_0000;

    // Merge only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/flyback_axil_wr_hold.sv
// Captures the AXI4-Lite AW and W channels independently and raises a commit
// request once both are held; readies stay low while a response is pending.
`timescale 1ns/1ps
module flyback_axil_wr_hold
    import flyback_axil_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        wstrb_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic              bvalid_i,
    output logic              commit_o,
    output logic [2:0]        idx_o,
    output logic [31:0]       data_o,
    output logic [3:0]        strb_o
);

    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic        en_q;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  strb_q, strb_d;
    logic        unused_addr;

    // en_q keeps both readies low through reset and for the first cycle after it.
    assign awready_o   = en_q & ~aw_held_q & ~bvalid_i;
    assign wready_o    = en_q & ~w_held_q & ~bvalid_i;
    assign commit_o    = aw_held_q & w_held_q;
    assign idx_o       = idx_q;
    assign data_o      = data_q;
    assign strb_o      = strb_q;
    assign unused_addr = ^awaddr_i[1:0];

    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        idx_d     = idx_q;
        data_d    = data_q;
        strb_d    = strb_q;
        if (commit_o) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else begin
            if (awvalid_i && awready_o) begin
                aw_held_d = 1'b1;
                idx_d     = awaddr_i[4:2];
            end
            if (wvalid_i && wready_o) begin
                w_held_d = 1'b1;
                data_d   = wdata_i;
                strb_d   = wstrb_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            en_q      <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            en_q      <= 1'b1;
            idx_q     <= idx_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
        end
    end

endmodule

// File: rtl/flyback_axil_regfile.sv
// AXI4-Lite register file for the flyback controller: four RW control words,
// a live status word and a version word, with per-word write strobes.
`timescale 1ns/1ps
module flyback_axil_regfile
    import flyback_axil_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] VERSION            = DEFAULT_VERSION
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [127:0]                    ctrl_o,
    output logic [3:0]                      ctrl_wr_o,
    input  logic [31:0]                     status_i
);

    logic [3:0][31:0] ctrl_q, ctrl_d;
    logic [3:0]       ctrl_wr_q, ctrl_wr_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;
    logic             commit;
    logic [2:0]       widx;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic [2:0]       ridx;
    logic             ar_hs;
    logic             unused_ok;

    flyback_axil_wr_hold #(
        .ADDR_W(C_S_AXI_ADDR_WIDTH)
    ) u_wr_hold (
        .clk_i    (ACLK),
        .rst_i    (ARESET),
        .awaddr_i (S_AXI_AWADDR),
        .awvalid_i(S_AXI_AWVALID),
        .awready_o(S_AXI_AWREADY),
        .wdata_i  (S_AXI_WDATA),
        .wstrb_i  (S_AXI_WSTRB),
        .wvalid_i (S_AXI_WVALID),
        .wready_o (S_AXI_WREADY),
        .bvalid_i (bvalid_q),
        .commit_o (commit),
        .idx_o    (widx),
        .data_o   (wdata),
        .strb_o   (wstrb)
    );

    assign ridx          = S_AXI_ARADDR[4:2];
    assign ar_hs         = S_AXI_ARVALID & ~rvalid_q;
    assign S_AXI_ARREADY = ~rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign ctrl_o        = ctrl_q;
    assign ctrl_wr_o     = ctrl_wr_q;
    assign unused_ok     = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0]};

    // Read-only and unmapped words never touch the control array or the strobes.
    always_comb begin
        ctrl_d    = ctrl_q;
        ctrl_wr_d = '0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            if (widx <= CTRL3) begin
                ctrl_d[widx[1:0]]    = apply_wstrb(ctrl_q[widx[1:0]], wdata, wstrb);
                ctrl_wr_d[widx[1:0]] = 1'b1;
            end else if (widx >= NUM_WORDS) begin
                bresp_d = RESP_SLVERR;
            end
        end
    end

    // Reads see ctrl_q before any write committing on the same edge.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            case (ridx)
                CTRL0, CTRL1, CTRL2, CTRL3: rdata_d = ctrl_q[ridx[1:0]];
                STATUS:                     rdata_d = status_i;
                VERSION_IDX:                rdata_d = VERSION;
                default: begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ctrl_q    <= '0;
            ctrl_wr_q <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            ctrl_q    <= ctrl_d;
            ctrl_wr_q <= ctrl_wr_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

endmodule

// File: tb/tb_flyback_axil_regfile.sv
// Scoreboard bench for flyback_axil_regfile: drivers push expected responses,
// a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_flyback_axil_regfile;

    logic         ACLK;
    logic         ARESET;
    logic [4:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [4:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] ctrl_o;
    logic [3:0]   ctrl_wr_o;
    logic [31:0]  status_i;

    flyback_axil_regfile dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWPROT (S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARPROT (S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY),
        .ctrl_o       (ctrl_o),
        .ctrl_wr_o    (ctrl_wr_o),
        .status_i     (status_i)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [1:0]   resp;
        logic [3:0]   strb;
        logic [127:0] ctrl;
    } bexp_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    bexp_t      bq[$];
    rexp_t      rq[$];
    logic [7:0] mem [4][4];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         awCyc  = 0;
    int         wCyc   = 0;
    logic       prevB  = 1'b0;

    // Every comparison funnels through here so the summary counts are exact.
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] snapshot();
        logic [127:0] s;
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 4; k++)
                s[32*w + 8*k +: 8] = mem[w][k];
        return s;
    endfunction

    function automatic logic probe(input int which);
        case (which)
            0:       return S_AXI_AWREADY;
            1:       return S_AXI_WREADY;
            2:       return S_AXI_ARREADY;
            3:       return S_AXI_BVALID;
            default: return S_AXI_RVALID;
        endcase
    endfunction

    // Bounded wait for a DUT signal, sampled on the falling edge.
    task automatic waitNeg(input int which, input string name);
        int t;
        t = 0;
        forever begin
            @(negedge ACLK);
            if (probe(which)) break;
            t++;
            if (t > 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s timeout: got 0 required 1", name);
                break;
            end
        end
    endtask

    task automatic doWrite(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int wLead, input int aLead, input int bDelay, input bit finishB);
        bexp_t e;
        int    idx;
        idx    = int'(addr[4:2]);
        e.resp = 2'b00;
        e.strb = 4'b0000;
        if (idx < 4) begin
            for (int k = 0; k < 4; k++)
                if (strb[k]) mem[idx][k] = data[8*k +: 8];
            e.strb = 4'(1 << idx);
        end else if (idx > 5) begin
            e.resp = 2'b10;
        end
        e.ctrl = snapshot();
        bq.push_back(e);
        @(posedge ACLK); #1;
        fork
            begin
                if (aLead > 0) begin repeat (aLead) @(posedge ACLK); #1; end
                S_AXI_AWADDR  = addr;
                S_AXI_AWVALID = 1'b1;
                waitNeg(0, "awready");
                @(posedge ACLK); #1;
                S_AXI_AWVALID = 1'b0;
            end
            begin
                if (wLead > 0) begin repeat (wLead) @(posedge ACLK); #1; end
                S_AXI_WDATA  = data;
                S_AXI_WSTRB  = strb;
                S_AXI_WVALID = 1'b1;
                waitNeg(1, "wready");
                @(posedge ACLK); #1;
                S_AXI_WVALID = 1'b0;
            end
        join
        if (finishB) begin
            if (bDelay > 0) begin repeat (bDelay) @(posedge ACLK); #1; end
            S_AXI_BREADY = 1'b1;
            waitNeg(3, "bvalid");
            @(posedge ACLK); #1;
            S_AXI_BREADY = 1'b0;
        end else begin
            waitNeg(3, "bvalid");
        end
    endtask

    task automatic doRead(input logic [4:0] addr, input int rDelay);
        rexp_t r;
        int    idx;
        idx    = int'(addr[4:2]);
        r.resp = 2'b00;
        if (idx < 4)       r.data = {mem[idx][3], mem[idx][2], mem[idx][1], mem[idx][0]};
        else if (idx == 4) r.data = status_i;
        else if (idx == 5) r.data = 32'h0001_0000;
        else begin
            r.data = 32'h0;
            r.resp = 2'b10;
        end
        rq.push_back(r);
        @(posedge ACLK); #1;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        waitNeg(2, "arready");
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        if (rDelay > 0) begin repeat (rDelay) @(posedge ACLK); #1; end
        S_AXI_RREADY = 1'b1;
        waitNeg(4, "rvalid");
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    // Read of word 2 handshakes on the very edge its pending write commits.
    task automatic doCollision(input logic [31:0] newData);
        rexp_t r;
        bexp_t e;
        r.data = {mem[2][3], mem[2][2], mem[2][1], mem[2][0]};
        r.resp = 2'b00;
        rq.push_back(r);
        for (int k = 0; k < 4; k++) mem[2][k] = newData[8*k +: 8];
        e.resp = 2'b00;
        e.strb = 4'b0100;
        e.ctrl = snapshot();
        bq.push_back(e);
        @(posedge ACLK); #1;
        S_AXI_AWADDR  = 5'h08;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = newData;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b1;
        S_AXI_RREADY  = 1'b1;
        waitNeg(0, "awready");
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARADDR  = 5'h08;
        S_AXI_ARVALID = 1'b1;
        waitNeg(2, "arready");
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        waitNeg(4, "rvalid");
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic applyStimulus(input int n);
        logic [4:0] addr;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) status_i = $urandom;
            addr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1)
                doWrite(addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
            else
                doRead(addr, int'($urandom_range(0, 3)));
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge ACLK) begin
        bexp_t be;
        rexp_t re;
        int    last;
        cyc++;
        if (ARESET) begin
            prevB = 1'b0;
        end else begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) awCyc = cyc;
            if (S_AXI_WVALID && S_AXI_WREADY) wCyc = cyc;
            if (S_AXI_BVALID && !prevB) begin
                if (bq.size() == 0) begin
                    checkOutput("b_unexpected", 128'(S_AXI_BVALID), 128'(0));
                end else begin
                    last = (awCyc > wCyc) ? awCyc : wCyc;
                    checkOutput("b_latency", 128'(cyc - last), 128'(2));
                    checkOutput("ctrl_wr_o", 128'(ctrl_wr_o), 128'(bq[0].strb));
                    checkOutput("ctrl_o", ctrl_o, bq[0].ctrl);
                end
            end else if (ctrl_wr_o != 4'b0000) begin
                checkOutput("ctrl_wr_stray", 128'(ctrl_wr_o), 128'(0));
            end
            if (S_AXI_BVALID && !S_AXI_BREADY) begin
                checkOutput("awready_blocked", 128'(S_AXI_AWREADY), 128'(0));
                checkOutput("wready_blocked", 128'(S_AXI_WREADY), 128'(0));
            end
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (bq.size() == 0) begin
                    checkOutput("b_unexpected", 128'(S_AXI_BVALID), 128'(0));
                end else begin
                    be = bq.pop_front();
                    checkOutput("bresp", 128'(S_AXI_BRESP), 128'(be.resp));
                end
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (rq.size() == 0) begin
                    checkOutput("r_unexpected", 128'(S_AXI_RVALID), 128'(0));
                end else begin
                    re = rq.pop_front();
                    checkOutput("rdata", 128'(S_AXI_RDATA), 128'(re.data));
                    checkOutput("rresp", 128'(S_AXI_RRESP), 128'(re.resp));
                end
            end
            prevB = S_AXI_BVALID;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] seqData [4];
        seqData = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 4; k++)
                mem[w][k] = 8'h00;
        ARESET        = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        status_i      = 32'h1234_5678;

        #490;
        checkOutput("rst_awready", 128'(S_AXI_AWREADY), 128'(0));
        checkOutput("rst_wready", 128'(S_AXI_WREADY), 128'(0));
        #10;
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        checkOutput("rst_ctrl_o", ctrl_o, 128'(0));
        checkOutput("rst_ctrl_wr", 128'(ctrl_wr_o), 128'(0));
        checkOutput("rst_bvalid", 128'(S_AXI_BVALID), 128'(0));
        checkOutput("rst_rvalid", 128'(S_AXI_RVALID), 128'(0));
        checkOutput("rst_arready", 128'(S_AXI_ARREADY), 128'(1));
        checkOutput("rst_rdata", 128'(S_AXI_RDATA), 128'(0));
        doRead(5'h14, 0);

        for (int i = 0; i < 4; i++) begin
            doWrite(5'(4 * i), seqData[i], 4'hF, 0, 0, 0, 1'b1);
            doRead(5'(4 * i), 0);
        end

        doWrite(5'h04, 32'hdeadbeef, 4'hF, 0, 5, 4, 1'b1);
        @(negedge ACLK);
        checkOutput("ctrl_word1", 128'(ctrl_o[63:32]), 128'(32'hdeadbeef));

        doWrite(5'h00, 32'h11223344, 4'hF, 0, 0, 0, 1'b1);
        doWrite(5'h00, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 1'b1);
        doRead(5'h00, 1);

        doWrite(5'h18, 32'h5555AAAA, 4'hF, 0, 0, 0, 1'b1);
        doRead(5'h1C, 0);
        doWrite(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 1'b1);
        status_i = 32'h0000CAFE;
        doRead(5'h10, 0);

        applyStimulus(80);

        doWrite(5'h08, 32'h0000_0001, 4'hF, 0, 0, 0, 1'b1);
        doCollision(32'h0000_0002);

        doWrite(5'h0C, 32'h600D_F00D, 4'hF, 0, 0, 0, 1'b0);
        #1;
        ARESET = 1'b1;
        #1;
        checkOutput("midrst_bvalid", 128'(S_AXI_BVALID), 128'(0));
        checkOutput("midrst_ctrl_o", ctrl_o, 128'(0));
        bq.delete();
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 4; k++)
                mem[w][k] = 8'h00;
        @(negedge ACLK);
        #2;
        ARESET = 1'b0;
        doRead(5'h0C, 0);

        repeat (5) @(negedge ACLK);
        checkOutput("bq_drained", 128'(bq.size()), 128'(0));
        checkOutput("rq_drained", 128'(rq.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
